// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes spi_slave byte frames (cmd + data/dummy bytes) into register-file reads and writes.
// Strobes are registered one cycle after the deciding input; no backpressure, reads wait up to RD_TIMEOUT for reg_rvalid.
module spi_reg_bridge #(
  parameter int ADDR_W     = 7,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rvalid,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_err
);

  localparam int TCNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WDATA    = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    RD_SHIFT = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic              armed, armed_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              tx_load_nxt, wr_en_nxt, rd_en_nxt, frame_done_nxt, rd_err_nxt;
  logic [7:0]        tx_data_nxt, wdata_nxt;
  logic [ADDR_W-1:0] reg_addr_nxt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      addr       <= '0;
      tcnt       <= '0;
      tx_load    <= 1'b0;
      tx_data    <= 8'h00;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= 8'h00;
      frame_done <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      armed      <= armed_nxt;
      addr       <= addr_nxt;
      tcnt       <= tcnt_nxt;
      tx_load    <= tx_load_nxt;
      tx_data    <= tx_data_nxt;
      reg_wr_en  <= wr_en_nxt;
      reg_rd_en  <= rd_en_nxt;
      reg_addr   <= reg_addr_nxt;
      reg_wdata  <= wdata_nxt;
      frame_done <= frame_done_nxt;
      rd_err     <= rd_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    // A frame already in progress when reset released is skipped until cs_n is seen high.
    armed_nxt      = armed | cs_n;
    addr_nxt       = addr;
    tcnt_nxt       = tcnt;
    tx_load_nxt    = 1'b0;
    tx_data_nxt    = tx_data;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    reg_addr_nxt   = reg_addr;
    wdata_nxt      = reg_wdata;
    frame_done_nxt = 1'b0;
    rd_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (!cs_n && armed) state_nxt = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          addr_nxt  = rx_data[ADDR_W-1:0];
          state_nxt = rx_data[7] ? WDATA : RD_REQ;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          wr_en_nxt    = 1'b1;
          reg_addr_nxt = addr;
          wdata_nxt    = rx_data;
          addr_nxt     = addr + ADDR_W'(1);
        end
      end
      RD_REQ: begin
        rd_en_nxt    = 1'b1;
        reg_addr_nxt = addr;
        tcnt_nxt     = '0;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT: begin
        // Data arriving on the timeout cycle still wins over the error path.
        if (reg_rvalid) begin
          tx_data_nxt = reg_rdata;
          tx_load_nxt = 1'b1;
          addr_nxt    = addr + ADDR_W'(1);
          state_nxt   = RD_SHIFT;
        end else if (tcnt == TCNT_W'(RD_TIMEOUT)) begin
          tx_data_nxt = 8'hFF;
          tx_load_nxt = 1'b1;
          rd_err_nxt  = 1'b1;
          addr_nxt    = addr + ADDR_W'(1);
          state_nxt   = RD_SHIFT;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      RD_SHIFT: begin
        if (rx_valid) state_nxt = RD_REQ;
      end
      default: state_nxt = IDLE;
    endcase

    // Frame end: a byte landing this cycle still writes, but read-side strobes are dropped.
    if (cs_n && (state != IDLE)) begin
      state_nxt      = IDLE;
      rd_en_nxt      = 1'b0;
      tx_load_nxt    = 1'b0;
      rd_err_nxt     = 1'b0;
      tx_data_nxt    = tx_data;
      frame_done_nxt = (state != CMD) || rx_valid;
    end
  end

endmodule
